// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type, default widths and drain-length helper
// for the systolic feeder, PE and array top.
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N          = 4;
    localparam int DEF_LEN_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Cycles after the last beat until the far-corner PE has seen its last operands.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage delay line for one lane, synchronously cleared to zero.
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   d      lane input
//   q      lane input delayed by DEPTH cycles
module skew_line
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts A/B beats over valid/ready, skews lane r by r+1 cycles
// onto the array edges and sequences start_operation through feed and drain.
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i, len_i         job start pulse and beat count (sampled in IDLE)
//   in_valid_i/in_ready_o  beat handshake
//   a_vec_i, b_vec_i       N packed lanes of DATA_WIDTH
//   a_row_o, b_col_o       skewed west/north edge lanes
//   start_operation_o      shared PE enable, high in FEED and DRAIN
//   busy_o, done_o         job active, one-cycle completion pulse
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        len_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [N*DATA_WIDTH-1:0] a_vec_i,
    input  logic [N*DATA_WIDTH-1:0] b_vec_i,
    output logic [N*DATA_WIDTH-1:0] a_row_o,
    output logic [N*DATA_WIDTH-1:0] b_col_o,
    output logic                    start_operation_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int DRAIN_LEN = drain_cycles(N);
    localparam int CW        = $clog2(DRAIN_LEN + 1);

    state_t           state, next;
    logic [LEN_W-1:0] len_q, beat_cnt;
    logic [CW-1:0]    drain_cnt;
    logic             accept, last_beat, drain_end;

    assign accept    = in_valid_i & in_ready_o;
    // Comparing against len-1 keeps a full-range length from wrapping the counter.
    assign last_beat = beat_cnt == len_q - LEN_W'(1);
    assign drain_end = drain_cnt == CW'(DRAIN_LEN - 1);

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start_i ? (len_i == '0 ? DONE : FEED) : IDLE;
            FEED:    next = accept && last_beat ? DRAIN : FEED;
            DRAIN:   next = drain_end ? DONE : DRAIN;
            default: next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            len_q             <= '0;
            beat_cnt          <= '0;
            drain_cnt         <= '0;
            in_ready_o        <= 1'b0;
            busy_o            <= 1'b0;
            start_operation_o <= 1'b0;
            done_o            <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && start_i) begin
                len_q    <= len_i;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
            drain_cnt         <= state == DRAIN ? drain_cnt + CW'(1) : '0;
            in_ready_o        <= next == FEED;
            busy_o            <= next == FEED || next == DRAIN;
            start_operation_o <= next == FEED || next == DRAIN;
            done_o            <= next == DONE;
        end
    end

    // Unaccepted cycles inject zeros so PEs see bubbles as no-ops.
    for (genvar r = 0; r < N; r++) begin : g_lane
        skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(r + 1)) a_line (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d     (accept ? a_vec_i[r*DATA_WIDTH +: DATA_WIDTH] : '0),
            .q     (a_row_o[r*DATA_WIDTH +: DATA_WIDTH])
        );
        skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(r + 1)) b_line (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d     (accept ? b_vec_i[r*DATA_WIDTH +: DATA_WIDTH] : '0),
            .q     (b_col_o[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed scenarios with a per-lane timed scoreboard.
module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] a_vec = '0;
    logic [N*DW-1:0] b_vec = '0;
    logic            in_ready, start_op, busy, done;
    logic [N*DW-1:0] a_row, b_col;

    systolic_feeder #(.DATA_WIDTH(DW), .N(N), .LEN_W(LW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .len_i             (len),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .a_vec_i           (a_vec),
        .b_vec_i           (b_vec),
        .a_row_o           (a_row),
        .b_col_o           (b_col),
        .start_operation_o (start_op),
        .busy_o            (busy),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            lane;
        logic [DW-1:0] val;
    } ev_t;

    ev_t q[$];
    int  done_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  mon_on = 1'b0;

    logic [DW-1:0] m_got, m_exp;
    int            m_idx;
    logic          m_done;

    // Lanes 0..N-1 are A, N..2N-1 are B; anything not scheduled must be zero.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int l = 0; l < 2 * N; l++) begin
                m_got = l < N ? a_row[l*DW +: DW] : b_col[(l-N)*DW +: DW];
                m_exp = '0;
                m_idx = -1;
                foreach (q[i]) if (q[i].cyc == cyc && q[i].lane == l) m_idx = i;
                if (m_idx >= 0) begin
                    m_exp = q[m_idx].val;
                    q.delete(m_idx);
                end
                checks++;
                assert (m_got === m_exp) else begin
                    errors++;
                    $error("FAIL lane%0d cyc=%0d got=%0h exp=%0h", l, cyc, m_got, m_exp);
                end
            end
            m_done = done_q.size() > 0 && done_q[0] == cyc;
            if (m_done) void'(done_q.pop_front());
            checks++;
            assert (done === m_done) else begin
                errors++;
                $error("FAIL done cyc=%0d got=%0b exp=%0b", cyc, done, m_done);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        len   = LW'(k);
        tick();
        start = 1'b0;
        len   = LW'($urandom);
        chk("feed_ready", in_ready, 1);
        chk("feed_startop", start_op, 1);
        chk("feed_busy", busy, 1);
    endtask

    // Beat driven now is accepted at the next edge; lane r shows it r+1 cycles later.
    task automatic beat(input logic [31:0] a, input logic [31:0] b, output int c);
        ev_t e;
        chk("beat_ready", in_ready, 1);
        c = cyc;
        for (int r = 0; r < N; r++) begin
            e.cyc = c + 1 + r; e.lane = r;     e.val = a[r*DW +: DW]; q.push_back(e);
            e.cyc = c + 1 + r; e.lane = r + N; e.val = b[r*DW +: DW]; q.push_back(e);
        end
        in_valid = 1'b1;
        a_vec    = a;
        b_vec    = b;
        tick();
        in_valid = 1'b0;
        a_vec    = $urandom;
        b_vec    = $urandom;
    endtask

    task automatic bubble();
        chk("bubble_ready", in_ready, 1);
        tick();
    endtask

    task automatic flush_future();
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc > cyc) q.delete(i);
        for (int i = done_q.size() - 1; i >= 0; i--) if (done_q[i] > cyc) done_q.delete(i);
    endtask

    task automatic job1(input logic [31:0] a, input logic [31:0] b);
        int c;
        start_job(1);
        beat(a, b, c);
        done_q.push_back(c + 2 * N);
        chk("j1_ready_drop", in_ready, 0);
        goto(c + 2 * N - 1);
        chk("j1_startop_last", start_op, 1);
        chk("j1_busy_last", busy, 1);
        goto(c + 2 * N);
        chk("j1_startop_done", start_op, 0);
        chk("j1_busy_done", busy, 0);
        goto(c + 2 * N + 1);
    endtask

    int c;

    initial begin
        // Reset with random inputs applied.
        start    = 1'b1;
        in_valid = 1'b1;
        len      = LW'($urandom);
        a_vec    = $urandom;
        b_vec    = $urandom;
        tick();
        mon_on = 1'b1;
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_startop", start_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a", a_row, 0);
        chk("rst_b", b_col, 0);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();

        // Single beat.
        job1(32'h04030201, 32'h08070605);

        // Back-to-back K=3.
        start_job(3);
        beat(32'h14131211, 32'h18171615, c);
        beat(32'h24232221, 32'h28272625, c);
        beat(32'h34333231, 32'h38373635, c);
        done_q.push_back(c + 2 * N);
        chk("b2b_ready_drop", in_ready, 0);
        goto(c + 2 * N + 1);

        // Bubble of two cycles after beat 1.
        start_job(3);
        beat(32'h44434241, 32'h48474645, c);
        bubble();
        bubble();
        beat(32'h54535251, 32'h58575655, c);
        beat(32'h64636261, 32'h68676665, c);
        done_q.push_back(c + 2 * N);
        chk("bub_ready_drop", in_ready, 0);
        goto(c + 2 * N + 1);

        // start_i during DRAIN is ignored.
        start_job(1);
        beat(32'h74737271, 32'h78777675, c);
        done_q.push_back(c + 2 * N);
        goto(c + 3);
        start = 1'b1;
        len   = LW'(5);
        tick();
        start = 1'b0;
        goto(c + 2 * N + 4);
        chk("ign_busy", busy, 0);
        chk("ign_ready", in_ready, 0);

        // Zero-length job.
        start = 1'b1;
        len   = '0;
        done_q.push_back(cyc + 1);
        tick();
        start = 1'b0;
        chk("zero_startop", start_op, 0);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_startop_after", start_op, 0);
        tick();

        // Reset in the third DRAIN cycle.
        start_job(1);
        beat(32'h84838281, 32'h88878685, c);
        done_q.push_back(c + 2 * N);
        goto(c + 3);
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        flush_future();
        tick();
        rst = 1'b0;
        chk("mid_startop", start_op, 0);
        chk("mid_busy", busy, 0);
        chk("mid_a", a_row, 0);
        chk("mid_b", b_col, 0);
        goto(c + 2 * N + 2);

        // Fresh job after reset.
        job1(32'h94939291, 32'h98979695);
        goto(cyc + 4);

        chk("sb_empty", q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the systolic PE array. Accepts one N-wide A vector and one N-wide B vector per beat over a valid/ready stream.
- Applies the diagonal skew the array needs: lane r is delayed r+1 cycles.
- Drives the west-edge A lanes and north-edge B lanes, plus the shared start_operation signal to every PE.
- Runs a feed/drain sequence so PE(N-1,N-1) sees its last operand pair before start_operation drops, then reports completion.

Parameters:
- DATA_WIDTH, 8, width of each A/B element (matches pe).
- N, 4, array dimension: number of lanes on each edge.
- LEN_W, 16, width of the beat-count input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  pulse that begins a job. Sampled only in IDLE.
- len_i  in  LEN_W  beats (K) in the job. Sampled with start_i.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  feeder accepts a beat.
- a_vec_i  in  N*DATA_WIDTH  A beat. Lane r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
- b_vec_i  in  N*DATA_WIDTH  B beat, same packing.
- a_row_o  out  N*DATA_WIDTH  skewed A lanes to the array's west edge.
- b_col_o  out  N*DATA_WIDTH  skewed B lanes to the array's north edge.
- start_operation_o  out  1  to every PE start_operation_i.
- busy_o  out  1  high in FEED or DRAIN.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. All outputs are registered.
- Reset values: all outputs 0. All skew registers 0. FSM in IDLE. Counters 0.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start_i=1 and len_i!=0: latch len_i, go to FEED.
  - start_i=1 and len_i==0: go to DONE; start_operation_o never asserts.
- FEED:
  - in_ready_o=1.
  - Accept on in_valid_i & in_ready_o; the beat counter increments.
  - On acceptance of beat K, go to DRAIN. in_ready_o drops the next cycle.
- DRAIN: hold for exactly 2N-1 cycles (7 for N=4), then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- start_operation_o = 1 in FEED and DRAIN; 0 in IDLE and DONE.
- busy_o = 1 in FEED and DRAIN.
- Skew injection: each cycle, the skew lines are loaded with the accepted beat, or with all-zeros if no beat was accepted (IDLE, DRAIN, DONE, or a FEED bubble).
- Bubbles: zeros contribute nothing to PE accumulation, so gaps in in_valid_i are legal. The beat count does not advance during a bubble.
- Skew timing: a beat accepted at cycle c drives lane r of a_row_o/b_col_o at cycle c+r+1. Other cycles on that lane carry zeros from the injection rule.
- Completion timing: with the last beat at cycle c, PE(N-1,N-1) samples its last operands at c+2N-1. DONE, and done_o, occurs at cycle c+2N.
- start_i while busy_o=1 or in DONE: ignored.
- len_i is sampled only with an accepted start_i. Changing it mid-job has no effect.
- Beat counter is LEN_W bits; K = 2^LEN_W-1 must complete without wrap.
- rst_i mid-job (any state): next cycle everything returns to reset values. No done_o pulse. Skew lines are flushed to zero.
- No arithmetic on data. Elements pass through unmodified, with width DATA_WIDTH.

Decomposition:
- Package systolic_pkg:
  - FSM state enum (IDLE/FEED/DRAIN/DONE).
  - Function drain_cycles(N) = 2N-1.
  - Lane slice helper / width constants shared with pe and the array top.
- Sub-module skew_line:
  - Parameters DATA_WIDTH and DEPTH.
  - A DEPTH-register delay chain with synchronous active-high reset to zero.
  - Instantiated 2N times with DEPTH=r+1.

Test Plan:
- Reset: assert rst_i 2 cycles, with random inputs applied -> all outputs 0, in_ready_o=0, FSM idle.
- Single beat, N=4: start_i with len_i=1; a_vec=[1,2,3,4], b_vec=[5,6,7,8] accepted at cycle c.
  - a lane0=1 at c+1, lane1=2 at c+2, lane2=3 at c+3, lane3=4 at c+4; B lanes likewise 5..8; zeros otherwise.
  - start_operation_o high from the FEED entry through c+7; done_o at c+8.
- Back-to-back K=3, in_valid_i held high: beats 1,2,3 appear on lane0 on consecutive cycles and on lane3 three cycles later. done_o at c_last+8. in_ready_o low after the third beat.
- Bubble: K=3 with in_valid_i low for 2 cycles after beat 1 -> the lanes show two zero slots between beats 1 and 2, the count holds, and done_o is delayed by 2 cycles.
- Ignored start and zero length:
  - start_i pulsed during DRAIN -> no effect, a single done_o.
  - start_i with len_i=0 -> done_o the next cycle, start_operation_o stays 0.
- Reset mid-DRAIN: rst_i at the 3rd DRAIN cycle -> next cycle all lanes 0, start_operation_o=0, no done_o. A fresh K=1 job then behaves as in scenario 2.
